// File: rtl/ofmap_writeback.sv
// Conv result writeback: per-channel rounding shift, optional ReLU and int8 saturation,
// stored into one output bank per channel at the raster pixel address.

module ofmap_lane #(
  parameter int IW    = 17,
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic                 clk,
  input  logic signed [IW-1:0] x,
  input  logic [4:0]           shift,
  input  logic                 relu,
  input  logic                 load,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [AW-1:0]        rd_addr,
  output logic                 sat,
  output logic [DW-1:0]        rd_q
);
  // Wide enough that a 31-bit rounding constant never overflows the input.
  localparam int RW = IW + 33;
  localparam logic signed [RW-1:0] MAXV = RW'(2**(DW-1) - 1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  logic signed [RW-1:0] r, y;
  logic [DW-1:0]        q, q1;
  logic [DW-1:0]        bank [DEPTH];

  always_comb begin
    r = $signed({{(RW-IW){x[IW-1]}}, x});
    if (shift != 5'd0) r = r + $signed(RW'(1) << (shift - 5'd1));
    y = r >>> shift;
    if (relu && y[RW-1]) y = '0;
    sat = 1'b0;
    q   = y[DW-1:0];
    if (y > MAXV) begin
      q   = MAXV[DW-1:0];
      sat = 1'b1;
    end else if (y < MINV) begin
      q   = MINV[DW-1:0];
      sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load)  q1 <= q;
    if (wr_en) bank[wr_addr] <= q1;
  end

  assign rd_q = bank[rd_addr];
endmodule

module ofmap_writeback #(
  parameter int dataSize      = 8,
  parameter int numInChannel  = 1,
  parameter int kernelWidth   = 3,
  parameter int numOutChannel = 3,
  parameter int numRegister   = 256,
  parameter int outputSize    = dataSize*2 + $clog2(numInChannel) + 1
) (
  input  logic                                     clk,
  input  logic                                     nrst,
  input  logic [15:0]                              cfg_ifmap_width,
  input  logic [4:0]                               cfg_shift,
  input  logic                                     cfg_relu,
  input  logic                                     ctrl_start,
  input  logic                                     in_valid,
  input  logic                                     in_done,
  input  logic [numOutChannel-1:0][outputSize-1:0] in_data,
  input  logic                                     rd_en,
  input  logic [$clog2(numOutChannel)-1:0]         rd_ch,
  input  logic [$clog2(numRegister)-1:0]           rd_addr,
  output logic [dataSize-1:0]                      rd_data,
  output logic                                     rd_valid,
  output logic                                     flag_busy,
  output logic                                     flag_done,
  output logic                                     flag_err,
  output logic [15:0]                              sat_cnt
);
  localparam int AW     = $clog2(numRegister);
  localparam int CW     = $clog2(numOutChannel);
  localparam int SAW    = $clog2(numOutChannel + 1);
  localparam int STAGES = 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                                 state;
  logic [AW:0]                            pix_cnt, pix_next;
  logic [33:0]                            n_pix, n_calc;
  logic [16:0]                            side;
  logic                                   cfg_bad, accept, wr_en;
  logic [4:0]                             shift;
  logic                                   relu;
  logic [AW-1:0]                          wr_addr;
  logic [STAGES:1]                        vld_pipe;
  logic [numOutChannel-1:0]               sat;
  logic [SAW-1:0]                         sat_add;
  logic [16:0]                            sat_sum;
  logic [numOutChannel-1:0][dataSize-1:0] lane_rd;

  assign accept    = (state == RUN) && in_valid;
  assign pix_next  = pix_cnt + (AW+1)'(accept);
  assign side      = {1'b0, cfg_ifmap_width} - 17'(kernelWidth) + 17'd1;
  assign n_calc    = 34'(side) * 34'(side);
  assign cfg_bad   = (cfg_ifmap_width < 16'(kernelWidth)) || (n_calc > 34'(numRegister));
  assign sat_sum   = {1'b0, sat_cnt} + 17'(sat_add);
  assign flag_busy = (state == RUN) || (state == FLUSH);
  // The write still in flight on a reset edge is dropped with the layer.
  assign wr_en     = vld_pipe[1] && nrst;

  always_comb begin
    sat_add = '0;
    for (int c = 0; c < numOutChannel; c++) sat_add = sat_add + SAW'(sat[c]);
  end

  for (genvar c = 0; c < numOutChannel; c++) begin : g_lane
    ofmap_lane #(.IW(outputSize), .DW(dataSize), .AW(AW), .DEPTH(numRegister)) u_lane (
      .clk(clk), .x($signed(in_data[c])), .shift(shift), .relu(relu), .load(accept),
      .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr), .sat(sat[c]), .rd_q(lane_rd[c])
    );
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      pix_cnt   <= '0;
      sat_cnt   <= '0;
      flag_err  <= 1'b0;
      flag_done <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      vld_pipe  <= '0;
    end else begin
      vld_pipe[1] <= accept;
      flag_done   <= 1'b0;
      if (accept) begin
        wr_addr <= pix_cnt[AW-1:0];
        pix_cnt <= pix_next;
        sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
      case (state)
        IDLE: if (ctrl_start) begin
          shift <= cfg_shift;
          relu  <= cfg_relu;
          n_pix <= n_calc;
          if (cfg_bad) flag_err <= 1'b1;
          else begin
            pix_cnt  <= '0;
            sat_cnt  <= '0;
            flag_err <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (34'(pix_next) == n_pix) state <= FLUSH;
          else if (in_done) begin
            flag_err <= 1'b1;
            state    <= FLUSH;
          end
        end
        FLUSH: begin
          if (in_valid) flag_err <= 1'b1;
          flag_done <= 1'b1;
          state     <= DONE;
        end
        default: begin
          if (in_valid) flag_err <= 1'b1;
          state <= IDLE;
        end
      endcase
      if (rd_en && (state == IDLE || state == DONE)) begin
        rd_valid <= 1'b1;
        rd_data  <= ({1'b0, rd_ch} < (CW+1)'(numOutChannel)) ? lane_rd[rd_ch] : '0;
      end else begin
        rd_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ofmap_writeback.sv
// Randomized layers against a transaction-level model of requant, bank contents,
// saturation count, error flag and done/busy timing.

module tb_ofmap_writeback;
  localparam int K = 3, NREG = 256, NCH = 3, OS = 17;

  typedef struct { bit v; int d; } rexp_t;

  logic                    clk = 1'b0, nrst = 1'b0;
  logic [15:0]             cfg_ifmap_width = '0;
  logic [4:0]              cfg_shift = '0;
  logic                    cfg_relu = 1'b0, ctrl_start = 1'b0, in_valid = 1'b0, in_done = 1'b0;
  logic [NCH-1:0][OS-1:0]  in_data = '0;
  logic                    rd_en = 1'b0;
  logic [1:0]              rd_ch = '0;
  logic [7:0]              rd_addr = '0;
  logic [7:0]              rd_data;
  logic                    rd_valid, flag_busy, flag_done, flag_err;
  logic [15:0]             sat_cnt;

  ofmap_writeback dut (
    .clk(clk), .nrst(nrst), .cfg_ifmap_width(cfg_ifmap_width), .cfg_shift(cfg_shift),
    .cfg_relu(cfg_relu), .ctrl_start(ctrl_start), .in_valid(in_valid), .in_done(in_done),
    .in_data(in_data), .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .flag_busy(flag_busy), .flag_done(flag_done), .flag_err(flag_err),
    .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  int    checks = 0, errors = 0;
  int    cyc = 0, busy_lo = 1, busy_hi = 0, done_cyc = -1, done_seen = -1, last_beat = 0;
  int    exp_sat = 0, cur_n = 0, cur_s = 0, pix = 0;
  bit    exp_err = 0, cur_relu = 0, mon_en = 0, calm = 0;
  int    mbank [NCH][NREG];
  bit    mknown [NCH][NREG];
  int    force0 [$];
  rexp_t rdq [$];

  function automatic void chk(string nm, longint act, longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
    end
  endfunction

  // Spec arithmetic: add half of 2^s, floor-divide by 2^s, relu, clamp to int8.
  function automatic int requant(int x, int s, bit relu, output bit sat);
    longint d, r, y;
    d = longint'(1) << s;
    r = longint'(x) + ((s > 0) ? d / 2 : 0);
    y = r / d;
    if (r < 0 && (r % d) != 0) y = y - 1;
    if (relu && y < 0) y = 0;
    sat = 1'b0;
    if (y > 127) begin y = 127; sat = 1'b1; end
    else if (y < -128) begin y = -128; sat = 1'b1; end
    return int'(y);
  endfunction

  function automatic int rand_x();
    if (calm) return int'($urandom_range(0, 200)) - 100;
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 255)) - 128;
      1:       return int'($urandom_range(0, 2000)) - 1000;
      2:       return int'($urandom_range(0, 131071)) - 65536;
      default: return int'($urandom_range(0, 600)) - 300;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (mon_en) begin
    rexp_t e;
    chk("flag_busy", longint'(flag_busy), longint'(cyc >= busy_lo && cyc <= busy_hi));
    chk("flag_done", longint'(flag_done), longint'(cyc == done_cyc));
    chk("flag_err", longint'(flag_err), longint'(exp_err));
    chk("sat_cnt", longint'(sat_cnt), longint'(exp_sat));
    if (flag_done) done_seen = cyc;
    if (rdq.size() > 0) begin
      e = rdq.pop_front();
      chk("rd_valid", longint'(rd_valid), longint'(e.v));
      if (e.v) chk("rd_data", longint'($signed(rd_data)), longint'(e.d));
    end else begin
      chk("rd_valid_idle", longint'(rd_valid), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(int w, int s, bit relu, output bit ok);
    cfg_ifmap_width = 16'(w);
    cfg_shift = 5'(s);
    cfg_relu = relu;
    ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
    ok = (w >= K) && ((w - K + 1) * (w - K + 1) <= NREG);
    if (ok) begin
      cur_n = (w - K + 1) * (w - K + 1);
      cur_s = s;
      cur_relu = relu;
      exp_sat = 0;
      exp_err = 0;
      busy_lo = cyc;
      busy_hi = 1 << 30;
      done_cyc = -1;
      pix = 0;
    end else begin
      exp_err = 1;
    end
  endtask

  task automatic gap();
    int g = int'($urandom_range(0, 2));
    for (int j = 0; j < g; j++) begin
      rd_en = ($urandom_range(0, 3) == 0);
      rd_ch = 2'($urandom_range(0, 2));
      rd_addr = 8'($urandom);
      ctrl_start = ($urandom_range(0, 5) == 0);
      cfg_ifmap_width = 16'($urandom_range(0, 30));
      cfg_shift = 5'($urandom);
      cfg_relu = 1'($urandom);
      tick();
      if (rd_en) rdq.push_back('{1'b0, 0});
      rd_en = 1'b0;
      ctrl_start = 1'b0;
    end
  endtask

  task automatic beat(bit done_too);
    int x, sc;
    bit st;
    sc = 0;
    for (int c = 0; c < NCH; c++) begin
      if (c == 0 && force0.size() > 0) x = force0.pop_front();
      else x = rand_x();
      in_data[c] = OS'(x);
      mbank[c][pix] = requant(x, cur_s, cur_relu, st);
      mknown[c][pix] = 1'b1;
      sc += int'(st);
    end
    in_valid = 1'b1;
    in_done = done_too;
    last_beat = cyc;
    tick();
    in_valid = 1'b0;
    in_done = 1'b0;
    exp_sat = (exp_sat + sc > 65535) ? 65535 : exp_sat + sc;
    pix++;
  endtask

  // m beats (m < N aborts via in_done); extra drives a stray beat into FLUSH.
  task automatic layer(int w, int s, bit relu, int m, bit done_same, bit extra, bit noise);
    bit ok;
    start(w, s, relu, ok);
    if (!ok) begin
      tick();
      return;
    end
    for (int i = 0; i < m && i < cur_n; i++) begin
      if (noise) gap();
      beat(done_same && (i == m - 1) && (m < cur_n));
    end
    if (m < cur_n && !(done_same && m > 0)) begin
      in_done = 1'b1;
      tick();
      in_done = 1'b0;
    end
    busy_hi = cyc;
    done_cyc = cyc + 1;
    if (m < cur_n) exp_err = 1;
    if (extra) begin
      in_valid = 1'b1;
      in_data[0] = OS'($urandom);
      tick();
      in_valid = 1'b0;
      exp_err = 1;
    end
    tick();
    tick();
  endtask

  task automatic rd1(int c, int a, int expv);
    rd_en = 1'b1;
    rd_ch = 2'(c);
    rd_addr = 8'(a);
    tick();
    rdq.push_back('{1'b1, expv});
    rd_en = 1'b0;
  endtask

  task automatic read_all(int upto);
    for (int a = 0; a < upto && a < NREG; a++)
      for (int c = 0; c < NCH; c++)
        if (mknown[c][a]) rd1(c, a, mbank[c][a]);
    tick();
    tick();
  endtask

  initial begin
    bit st, ok;
    int n, w;
    for (int c = 0; c < NCH; c++) for (int a = 0; a < NREG; a++) mknown[c][a] = 1'b0;
    repeat (3) tick();
    chk("rst_busy", longint'(flag_busy), 0);
    chk("rst_done", longint'(flag_done), 0);
    chk("rst_err", longint'(flag_err), 0);
    chk("rst_sat", longint'(sat_cnt), 0);
    chk("rst_rd_valid", longint'(rd_valid), 0);
    chk("rst_rd_data", longint'(rd_data), 0);
    nrst = 1'b1;
    mon_en = 1'b1;
    tick();

    chk("rq_7_s1", requant(7, 1, 0, st), 4);
    chk("rq_m7_s1", requant(-7, 1, 0, st), -3);
    chk("rq_m8_s1", requant(-8, 1, 0, st), -4);
    chk("rq_m50_relu", requant(-50, 2, 1, st), 0);
    chk("rq_50_s2", requant(50, 2, 1, st), 13);
    chk("rq_200_sat", requant(200, 0, 0, st), 127);
    chk("rq_200_satflag", longint'(st), 1);

    // Directed W=5 layer, ch0 = 5,-3,200, everything else in range.
    calm = 1;
    force0 = '{5, -3, 200, 1, 2, 3, 4, 5, 6};
    layer(5, 0, 0, 9, 0, 0, 0);
    calm = 0;
    chk("dir_done_lat", done_seen - last_beat, 2);
    chk("dir_sat", longint'(sat_cnt), 1);
    chk("dir_err", longint'(flag_err), 0);
    rd1(0, 0, 5);
    rd1(0, 1, -3);
    rd1(0, 2, 127);
    read_all(9);

    // Abort after 5 of 9: entries 5..8 keep the previous layer's data.
    layer(5, 1, 0, 5, 0, 0, 1);
    chk("abort_err", longint'(flag_err), 1);
    read_all(9);
    layer(5, 2, 1, 9, 0, 0, 1);
    read_all(9);

    layer(20, 0, 0, 0, 0, 0, 0);
    chk("w20_err", longint'(flag_err), 1);
    chk("w20_busy", longint'(flag_busy), 0);
    layer(2, 0, 0, 0, 0, 0, 0);
    chk("w2_err", longint'(flag_err), 1);
    layer(19, 0, 0, 0, 0, 0, 0);
    chk("w19_err", longint'(flag_err), 1);

    // Reset in the middle of a layer.
    start(5, 0, 0, ok);
    for (int i = 0; i < 4; i++) beat(0);
    nrst = 1'b0;
    tick();
    exp_sat = 0;
    exp_err = 0;
    busy_hi = cyc - 1;
    done_cyc = -1;
    for (int c = 0; c < NCH; c++) mknown[c][3] = 1'b0;
    chk("mid_rst_busy", longint'(flag_busy), 0);
    tick();
    nrst = 1'b1;
    tick();
    done_seen = -1;
    layer(5, 0, 0, 9, 0, 0, 1);
    chk("post_rst_err", longint'(flag_err), 0);
    chk("post_rst_done_seen", longint'(done_seen > 0), 1);
    read_all(9);

    // Boundaries: N=1 and N=numRegister.
    layer(3, 3, 0, 1, 0, 0, 0);
    read_all(2);
    layer(18, 4, 0, 256, 0, 1, 1);
    read_all(256);

    for (int it = 0; it < 8; it++) begin
      w = int'($urandom_range(3, 18));
      n = (w - K + 1) * (w - K + 1);
      layer(w, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6)),
            1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : n,
            1'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
      read_all(n + 4);
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
